// File: rtl/uart_pkg.sv
// Shared UART definitions for the parameter-RAM readback transmitter and the receive path.
package uart_pkg;

    localparam int   DEFAULT_CLKS_PER_BIT = 434;   // 50 MHz / 115200 baud
    localparam logic UART_IDLE_LEVEL      = 1'b1;
    localparam int   UART_DATA_BITS       = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LATCH,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_DONE
    } tx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running bit-period counter: one-cycle tick on the last cycle of every CLKS_PER_BIT window.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // A clear restarts the window, so it must also suppress a coincident tick.
    assign o_tick = (r_cnt == LAST) && !i_clear;

endmodule

// File: rtl/ram_readback_tx.sv
// Reads NUM_BYTES bytes from the parameter RAM starting at BASE_ADDR and sends each as UART 8N1.
module ram_readback_tx
    import uart_pkg::*;
#(
    parameter int         CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter logic [7:0] BASE_ADDR    = 8'd4,
    parameter int         NUM_BYTES    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [7:0] rd_addr,
    output logic       rd_en,
    input  logic [7:0] rd_data,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [8:0] LAST_BYTE = 9'(NUM_BYTES - 1);
    localparam logic [2:0] LAST_BIT  = 3'(UART_DATA_BITS - 1);

    tx_state_t  r_state, w_state_next;
    logic [7:0] r_addr, w_addr_next;
    logic [7:0] r_shift, w_shift_next;
    logic [2:0] r_bit_cnt, w_bit_cnt_next;
    logic [8:0] r_byte_cnt, w_byte_cnt_next;
    logic       r_tx, w_tx_next;
    logic       r_busy, w_busy_next;
    logic       r_done, w_done_next;
    logic       r_rd_en, w_rd_en_next;
    logic       w_baud_clear;
    logic       w_tick;

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (w_baud_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_addr     <= BASE_ADDR;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_tx       <= UART_IDLE_LEVEL;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rd_en    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_addr     <= w_addr_next;
            r_shift    <= w_shift_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_byte_cnt <= w_byte_cnt_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
            r_rd_en    <= w_rd_en_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_addr_next     = r_addr;
        w_shift_next    = r_shift;
        w_bit_cnt_next  = r_bit_cnt;
        w_byte_cnt_next = r_byte_cnt;
        w_baud_clear    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = ST_FETCH;
                end
            end
            ST_FETCH: begin
                w_state_next = ST_LATCH;
            end
            ST_LATCH: begin
                w_shift_next = rd_data;
                w_baud_clear = 1'b1;
                w_state_next = ST_START;
            end
            ST_START: begin
                if (w_tick) begin
                    w_bit_cnt_next = '0;
                    w_state_next   = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == LAST_BIT) begin
                        w_state_next = ST_STOP;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_byte_cnt == LAST_BYTE) begin
                        w_state_next = ST_DONE;
                    end else begin
                        w_addr_next     = r_addr + 8'd1;
                        w_byte_cnt_next = r_byte_cnt + 9'd1;
                        w_state_next    = ST_FETCH;
                    end
                end
            end
            ST_DONE: begin
                w_addr_next     = BASE_ADDR;
                w_byte_cnt_next = '0;
                w_state_next    = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the upcoming state so they leave the flops glitch-free.
        w_rd_en_next = (w_state_next == ST_FETCH);
        w_done_next  = (w_state_next == ST_DONE);
        w_busy_next  = (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
        case (w_state_next)
            ST_START: w_tx_next = ~UART_IDLE_LEVEL;
            ST_DATA:  w_tx_next = w_shift_next[0];
            default:  w_tx_next = UART_IDLE_LEVEL;
        endcase
    end

    assign rd_addr = r_addr;
    assign rd_en   = r_rd_en;
    assign tx      = r_tx;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
